// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Arbitrates the single register-file write port between the in-order
//   pipeline writeback stage and a long-latency auxiliary unit. The
//   auxiliary results are staged in a 2-entry FIFO.
//   - The pipeline always wins the port, with no added latency.
//   - FIFO entries drain in acceptance order whenever the pipeline is idle.
//
//   Optional feature (macro WB_STARVE_GUARD_EN):
//   - A starvation counter tracks how many consecutive cycles a non-empty
//     buffer has lost the port.
//   - After STARVE_LIMIT such cycles, stall_req asks the pipeline controller
//     for a writeback bubble.
//   - stall_req stays high until the cycle after the next drain.
//   - When the macro is undefined, stall_req is tied to 0.
//
// Ports
//   Clock          rising-edge clock
//   Resetn         synchronous active-low reset
//   Alu_Result_wb  pipeline ALU result
//   mo_wb          pipeline load data
//   m2reg_wb       1: write mo_wb, 0: write Alu_Result_wb
//   wn_wb          pipeline destination register
//   wreg_wb        pipeline write request (highest priority)
//   aux_valid      aux result offered (producer holds it while aux_ready=0)
//   aux_wn         aux destination register
//   aux_data       aux result
//   aux_ready      buffer not full
//   rf_we          register-file write enable
//   rf_wn          register-file write address
//   rf_wd          register-file write data
//   stall_req      writeback-bubble request (registered)
//   buf_count      buffer occupancy 0..2
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [31:0] Alu_Result_wb,
    input  logic [31:0] mo_wb,
    input  logic        m2reg_wb,
    input  logic [4:0]  wn_wb,
    input  logic        wreg_wb,
    input  logic        aux_valid,
    input  logic [4:0]  aux_wn,
    input  logic [31:0] aux_data,
    output logic        aux_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wn,
    output logic [31:0] rf_wd,
    output logic        stall_req,
    output logic [1:0]  buf_count
);

    typedef struct packed {
        logic [4:0]  wn;
        logic [31:0] data;
    } aux_entry_t;

    aux_entry_t [1:0] r_buf;
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic             w_push;
    logic             w_aux_grant;
    logic             w_pop;
    aux_entry_t       w_head;

    assign aux_ready = (r_count != 2'd2);
    assign buf_count = r_count;
    assign w_push    = aux_valid & aux_ready;
    assign w_head    = r_buf[r_rptr];

    // The head is only granted outside reset so a buffer being flushed never
    // reaches the register file during the reset cycle.
    assign w_aux_grant = Resetn & ~wreg_wb & (r_count != 2'd0);
    assign w_pop       = w_aux_grant;

    // Write-port mux: pipeline first, then buffer head, else all zeros.
    always_comb begin
        rf_we = 1'b0;
        rf_wn = 5'd0;
        rf_wd = 32'd0;
        if (wreg_wb) begin
            rf_we = 1'b1;
            rf_wn = wn_wb;
            rf_wd = m2reg_wb ? mo_wb : Alu_Result_wb;
        end else if (w_aux_grant) begin
            rf_we = 1'b1;
            rf_wn = w_head.wn;
            rf_wd = w_head.data;
        end
    end

    // FIFO storage and pointers. A push into a 1-entry buffer concurrent with
    // a pop writes the other slot, so ordering is preserved.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_buf   <= '0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf[r_wptr] <= '{wn: aux_wn, data: aux_data};
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] r_starve_cnt;
    logic [2:0] w_starve_cnt_nxt;
    logic       r_stall;
    logic       w_stall_nxt;

    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (w_pop || (r_count == 2'd0)) begin
            w_starve_cnt_nxt = 3'd0;
        end else if (wreg_wb && (r_starve_cnt != LIMIT)) begin
            w_starve_cnt_nxt = r_starve_cnt + 3'd1;
        end
    end

    // Set on the edge where the counter lands on the limit, so stall_req is
    // visible in the cycle after the counter reaches it. A pop clears it.
    always_comb begin
        w_stall_nxt = r_stall | (w_starve_cnt_nxt == LIMIT);
        if (w_pop) begin
            w_stall_nxt = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_starve_cnt <= 3'd0;
            r_stall      <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
            r_stall      <= w_stall_nxt;
        end
    end

    assign stall_req = r_stall;
`else
    logic w_unused_limit;
    assign w_unused_limit = (STARVE_LIMIT == 0);
    assign stall_req      = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [31:0] Alu_Result_wb;
    logic [31:0] mo_wb;
    logic        m2reg_wb;
    logic [4:0]  wn_wb;
    logic        wreg_wb;
    logic        aux_valid;
    logic [4:0]  aux_wn;
    logic [31:0] aux_data;
    logic        aux_ready;
    logic        rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_wd;
    logic        stall_req;
    logic [1:0]  buf_count;

    int n_chk = 0;
    int n_err = 0;

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .Alu_Result_wb(Alu_Result_wb),
        .mo_wb        (mo_wb),
        .m2reg_wb     (m2reg_wb),
        .wn_wb        (wn_wb),
        .wreg_wb      (wreg_wb),
        .aux_valid    (aux_valid),
        .aux_wn       (aux_wn),
        .aux_data     (aux_data),
        .aux_ready    (aux_ready),
        .rf_we        (rf_we),
        .rf_wn        (rf_wn),
        .rf_wd        (rf_wd),
        .stall_req    (stall_req),
        .buf_count    (buf_count)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are changed 1 time unit after it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] wn, input logic [31:0] wd);
        #1;
        chk({tag, ".we"}, 32'(rf_we), 32'(we));
        chk({tag, ".wn"}, 32'(rf_wn), 32'(wn));
        chk({tag, ".wd"}, rf_wd, wd);
    endtask

    task automatic pipe(input logic we, input logic [4:0] wn, input logic [31:0] alu);
        wreg_wb       = we;
        wn_wb         = wn;
        Alu_Result_wb = alu;
        m2reg_wb      = 1'b0;
    endtask

    task automatic aux(input logic v, input logic [4:0] wn, input logic [31:0] d);
        aux_valid = v;
        aux_wn    = wn;
        aux_data  = d;
    endtask

    logic exp_stall;

    initial begin
        Resetn = 1'b0;
        pipe(1'b0, 5'd0, 32'd0);
        mo_wb = 32'd0;
        aux(1'b0, 5'd0, 32'd0);

        // Reset for two edges, release with idle inputs.
        step();
        step();
        Resetn = 1'b1;
        chk_rf("rst_idle", 1'b0, 5'd0, 32'd0);
        chk("rst_count", 32'(buf_count), 32'd0);
        chk("rst_ready", 32'(aux_ready), 32'd1);
        chk("rst_stall", 32'(stall_req), 32'd0);
        step();

        // Pipeline path, load and ALU select, same cycle.
        wreg_wb = 1'b1; wn_wb = 5'd5; m2reg_wb = 1'b1;
        mo_wb = 32'hDEADBEEF; Alu_Result_wb = 32'h1;
        chk_rf("pipe_load", 1'b1, 5'd5, 32'hDEADBEEF);
        m2reg_wb = 1'b0;
        chk_rf("pipe_alu", 1'b1, 5'd5, 32'h1);
        step();

        // Back-to-back aux results with idle pipeline.
        pipe(1'b0, 5'd0, 32'd0);
        aux(1'b1, 5'd7, 32'h11);
        chk_rf("aux_nobypass", 1'b0, 5'd0, 32'd0);
        step();
        aux(1'b1, 5'd8, 32'h22);
        chk_rf("aux_first", 1'b1, 5'd7, 32'h11);
        chk("aux_cnt1", 32'(buf_count), 32'd1);
        step();
        aux(1'b0, 5'd0, 32'd0);
        chk_rf("aux_second", 1'b1, 5'd8, 32'h22);
        chk("aux_cnt_pushpop", 32'(buf_count), 32'd1);
        step();
        chk_rf("aux_drained", 1'b0, 5'd0, 32'd0);
        chk("aux_cnt0", 32'(buf_count), 32'd0);

        // Fill while the pipeline owns the port; third offer refused.
        pipe(1'b1, 5'd9, 32'h55);
        aux(1'b1, 5'd3, 32'hA);
        chk("fill_ready0", 32'(aux_ready), 32'd1);
        step();
        aux(1'b1, 5'd4, 32'hB);
        chk_rf("fill_pipe_wins", 1'b1, 5'd9, 32'h55);
        step();
        aux(1'b1, 5'd5, 32'hC);
        #1;
        chk("fill_full", 32'(buf_count), 32'd2);
        chk("fill_not_ready", 32'(aux_ready), 32'd0);
        step();
        aux(1'b0, 5'd0, 32'd0);
        pipe(1'b0, 5'd0, 32'd0);
        chk("fill_still_full", 32'(buf_count), 32'd2);
        chk_rf("drain_first", 1'b1, 5'd3, 32'hA);
        step();
        chk_rf("drain_second", 1'b1, 5'd4, 32'hB);
        step();
        chk_rf("drain_done", 1'b0, 5'd0, 32'd0);
        chk("drain_cnt", 32'(buf_count), 32'd0);

        // Starvation: one buffered entry loses for six cycles. Register 0 is
        // used to show it is not filtered.
        pipe(1'b1, 5'd1, 32'h100);
        aux(1'b1, 5'd0, 32'h77);
        step();
        aux(1'b0, 5'd0, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            pipe(1'b1, 5'(k + 10), 32'(k));
`ifdef WB_STARVE_GUARD_EN
            exp_stall = (k >= 5);
`else
            exp_stall = 1'b0;
`endif
            #1;
            chk($sformatf("starve_stall_c%0d", k), 32'(stall_req), 32'(exp_stall));
            chk_rf($sformatf("starve_pipe_c%0d", k), 1'b1, 5'(k + 10), 32'(k));
            step();
        end
        pipe(1'b0, 5'd0, 32'd0);
`ifdef WB_STARVE_GUARD_EN
        exp_stall = 1'b1;
`else
        exp_stall = 1'b0;
`endif
        chk_rf("starve_pop_r0", 1'b1, 5'd0, 32'h77);
        chk("starve_stall_popcyc", 32'(stall_req), 32'(exp_stall));
        step();
        #1;
        chk("starve_stall_clear", 32'(stall_req), 32'd0);
        chk("starve_cnt0", 32'(buf_count), 32'd0);

        // Reset with a full buffer: nothing written, offer in reset ignored.
        pipe(1'b1, 5'd2, 32'h2);
        aux(1'b1, 5'd1, 32'h1111);
        step();
        aux(1'b1, 5'd2, 32'h2222);
        step();
        aux(1'b1, 5'd6, 32'h66);
        pipe(1'b0, 5'd0, 32'd0);
        Resetn = 1'b0;
        chk_rf("rstmid_nowrite", 1'b0, 5'd0, 32'd0);
        step();
        Resetn = 1'b1;
        aux(1'b0, 5'd0, 32'd0);
        chk_rf("rstmid_after", 1'b0, 5'd0, 32'd0);
        chk("rstmid_cnt", 32'(buf_count), 32'd0);
        chk("rstmid_ready", 32'(aux_ready), 32'd1);
        chk("rstmid_stall", 32'(stall_req), 32'd0);
        step();
        chk_rf("rstmid_next", 1'b0, 5'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
